// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter and its picker.
//   state_t         : arbiter FSM states (IDLE / ACCESS / RESP)
//   PORT_C, PORT_L  : requester indices (core = 0, loader = 1)
//   WAIT_CNT_W      : width of the wait-state counter
//   addr_legal()    : word-aligned and inside the memory window
// Optional build macro used by the importing files: DMEM_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_C     = 1'b0;
    localparam logic PORT_L     = 1'b1;
    localparam int   WAIT_CNT_W = 4;

    // Compared at 34 bits so a memory of 2^30 words cannot wrap the limit.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input int unsigned mem_words);
        logic [33:0] limit;
        limit = 34'(mem_words) * 34'd4;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational two-way picker with request masking.
//   req[1:0]    in  : raw requests, bit PORT_C = core, bit PORT_L = loader
//   mask[1:0]   in  : requests to ignore this cycle
//   last_grant  in  : port granted most recently
//   gnt[1:0]    out : one-hot grant (00 when nothing live)
// Build macro DMEM_ARB_FIXED_PRIO_EN: defined -> core always wins a tie;
// undefined -> a tie goes to the port that was not granted last.
// ---------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    logic [1:0] live;
    logic       tie_to_l;

    assign live = req & ~mask;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_to_l          = 1'b0;
`else
    assign tie_to_l = (last_grant == PORT_C);
`endif

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (live)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = tie_to_l ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between the core (C) and the loader (L).
// Each access: arbitrate in IDLE, hold strobes in ACCESS for WAIT_STATES+1
// cycles, pulse ready for one cycle in RESP.
//   clk, reset                 : clock (rising), async active-low reset
//   c_req/c_we/c_addr/c_wdata  : core request, held until c_ready
//   c_rdata/c_ready/c_err      : core response, valid while c_ready=1
//   l_*                        : loader port, same meaning as core port
//   mem_read_control           : read strobe, every ACCESS cycle of a load
//   mem_write_control          : write strobe, last ACCESS cycle of a store
//   mem_address, mem_data_in   : latched address / store data
//   mem_data_out               : combinational memory read data
//   busy                       : FSM not in IDLE
// Build macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority (core wins ties)
// instead of round-robin.
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_ready,
    output logic        c_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic [31:0] l_rdata,
    output logic        l_ready,
    output logic        l_err,
    output logic        mem_read_control,
    output logic        mem_write_control,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    state_t                state, state_next;
    logic [1:0]            gnt;
    logic [1:0]            mask;
    logic                  last_grant;
    logic                  win_port;
    logic                  win_we;
    logic [31:0]           win_addr;
    logic [31:0]           win_wdata;
    logic                  win_legal;
    logic                  port_q;
    logic                  we_q;
    logic                  err_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [WAIT_CNT_W-1:0] cnt;

    dmem_arb_pick u_pick (
        .req        ({l_req, c_req}),
        .mask       (mask),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign win_port  = gnt[PORT_L] ? PORT_L : PORT_C;
    assign win_we    = (win_port == PORT_L) ? l_we    : c_we;
    assign win_addr  = (win_port == PORT_L) ? l_addr  : c_addr;
    assign win_wdata = (win_port == PORT_L) ? l_wdata : c_wdata;
    assign win_legal = addr_legal(win_addr, MEMORY_SIZE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Strobes decode from the state register only, so an async reset that
    // forces IDLE drops them immediately.
    always_comb begin
        state_next        = state;
        mem_read_control  = 1'b0;
        mem_write_control = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt != 2'b00) state_next = win_legal ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                mem_read_control  = !we_q;
                mem_write_control = we_q && (cnt == '0);
                if (cnt == '0) state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: the datapath latches are reset too, because every output,
    // including mem_address and mem_data_in, must read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_L;   // makes the first tie after reset go to C
            mask       <= 2'b00;
            port_q     <= PORT_C;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The mask lives for exactly one IDLE cycle.
                    mask <= 2'b00;
                    if (gnt != 2'b00) begin
                        port_q     <= win_port;
                        last_grant <= win_port;
                        we_q       <= win_we;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        err_q      <= !win_legal;
                        rdata_q    <= '0;
                        cnt        <= WAIT_CNT_W'(WAIT_STATES);
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0)  cnt     <= cnt - WAIT_CNT_W'(1);
                    else if (!we_q) rdata_q <= mem_data_out;
                end
                ST_RESP: begin
                    // Give the served requester one cycle to drop its req.
                    mask <= (port_q == PORT_L) ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

    assign c_ready = (state == ST_RESP) && (port_q == PORT_C);
    assign l_ready = (state == ST_RESP) && (port_q == PORT_L);
    assign c_rdata = c_ready ? rdata_q : '0;
    assign l_rdata = l_ready ? rdata_q : '0;
    assign c_err   = c_ready && err_q;
    assign l_err   = l_ready && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter (WAIT_STATES=3, MEMORY_SIZE=256).
// A transaction-level model predicts, in absolute cycle numbers, when each
// access is granted, strobed and answered; one process compares every DUT
// output against it on each falling edge. Directed sequences pin latency,
// errors, arbitration order and reset-abort with literal expectations.
// Honours DMEM_ARB_FIXED_PRIO_EN for the expected tie order.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 256;
    localparam int WS        = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        l_req = 1'b0, l_we = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic [31:0] c_rdata, l_rdata;
    logic        c_ready, l_ready, c_err, l_err;
    logic        mem_read_control, mem_write_control, busy;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    dmem_arbiter #(.MEMORY_SIZE(MEM_WORDS), .WAIT_STATES(WS)) dut (
        .clk               (clk),
        .reset             (rst_n),
        .c_req             (c_req),
        .c_we              (c_we),
        .c_addr            (c_addr),
        .c_wdata           (c_wdata),
        .c_rdata           (c_rdata),
        .c_ready           (c_ready),
        .c_err             (c_err),
        .l_req             (l_req),
        .l_we              (l_we),
        .l_addr            (l_addr),
        .l_wdata           (l_wdata),
        .l_rdata           (l_rdata),
        .l_ready           (l_ready),
        .l_err             (l_err),
        .mem_read_control  (mem_read_control),
        .mem_write_control (mem_write_control),
        .mem_address       (mem_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Memory instance model: combinational read, write on rising edge.
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    assign mem_data_out = mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write_control) mem[mem_address[9:2]] = mem_data_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- port access helpers ----------------
    function automatic logic p_req(input int p);            return p != 0 ? l_req   : c_req;   endfunction
    function automatic logic p_we(input int p);             return p != 0 ? l_we    : c_we;    endfunction
    function automatic logic [31:0] p_addr(input int p);    return p != 0 ? l_addr  : c_addr;  endfunction
    function automatic logic [31:0] p_wdata(input int p);   return p != 0 ? l_wdata : c_wdata; endfunction
    function automatic logic p_ready(input int p);          return p != 0 ? l_ready : c_ready; endfunction
    function automatic logic p_err(input int p);            return p != 0 ? l_err   : c_err;   endfunction
    function automatic logic [31:0] p_rdata(input int p);   return p != 0 ? l_rdata : c_rdata; endfunction

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p != 0) begin l_req = r; l_we = w; l_addr = a; l_wdata = d; end
        else        begin c_req = r; c_we = w; c_addr = a; c_wdata = d; end
    endtask

    // ---------------- behavioural model ----------------
    // One transaction at a time, described by the cycle numbers of its grant,
    // strobe window and ready pulse.
    int          cyc, free_at, mask_cyc, mask_port, last_gnt;
    int          grant_cyc, acc_lo, acc_hi, ready_at, txn_port;
    bit          txn_valid, txn_we, txn_legal;
    logic [31:0] txn_addr, txn_wdata, txn_rdata, exp_maddr, exp_mdin;

    task automatic model_reset();
        cyc = 0; free_at = 0; mask_cyc = -1; mask_port = 0; last_gnt = 1;
        grant_cyc = -1; acc_lo = -1; acc_hi = -1; ready_at = -1; txn_port = 0;
        txn_valid = 0; txn_we = 0; txn_legal = 0;
        txn_addr = '0; txn_wdata = '0; txn_rdata = '0; exp_maddr = '0; exp_mdin = '0;
    endtask

    function automatic bit in_progress(input int p);
        return txn_valid && txn_port == p && cyc > grant_cyc && cyc <= ready_at;
    endfunction

    task automatic model_cycle();
        int          k, w;
        logic [1:0]  e_rdy, live;
        bit          e_busy, e_rd, e_wr;
        k      = cyc;
        e_busy = txn_valid && k > grant_cyc && k <= ready_at;
        e_rd   = txn_valid && txn_legal && !txn_we && k >= acc_lo && k <= acc_hi;
        e_wr   = txn_valid && txn_legal &&  txn_we && k == acc_hi;
        e_rdy  = 2'b00;
        if (txn_valid && k == ready_at) e_rdy[txn_port] = 1'b1;

        check("busy", 32'(busy), 32'(e_busy));
        check("mem_read_control", 32'(mem_read_control), 32'(e_rd));
        check("mem_write_control", 32'(mem_write_control), 32'(e_wr));
        check("mem_address", mem_address, exp_maddr);
        check("mem_data_in", mem_data_in, exp_mdin);
        for (int p = 0; p < 2; p++) begin
            check(p != 0 ? "l_ready" : "c_ready", 32'(p_ready(p)), 32'(e_rdy[p]));
            check(p != 0 ? "l_rdata" : "c_rdata", p_rdata(p), e_rdy[p] ? txn_rdata : 32'h0);
            check(p != 0 ? "l_err" : "c_err", 32'(p_err(p)), e_rdy[p] ? 32'(!txn_legal) : 32'h0);
        end

        if (e_wr) ref_mem[txn_addr[9:2]] = txn_wdata;

        if (k >= free_at) begin
            live = {l_req, c_req};
            if (k == mask_cyc) live[mask_port] = 1'b0;
            if (live != 2'b00) begin
                if (live == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = (last_gnt == 0) ? 1 : 0;
`endif
                end else begin
                    w = live[1] ? 1 : 0;
                end
                last_gnt  = w;
                txn_valid = 1;
                txn_port  = w;
                txn_we    = p_we(w);
                txn_addr  = p_addr(w);
                txn_wdata = p_wdata(w);
                txn_legal = (txn_addr % 4 == 0) && (txn_addr < MEM_WORDS * 4);
                grant_cyc = k;
                if (txn_legal) begin
                    acc_lo   = k + 1;
                    acc_hi   = k + 1 + WS;
                    ready_at = k + 2 + WS;
                end else begin
                    acc_lo   = -1;
                    acc_hi   = -1;
                    ready_at = k + 1;
                end
                txn_rdata = (txn_legal && !txn_we) ? ref_mem[txn_addr[9:2]] : 32'h0;
                free_at   = ready_at + 1;
                mask_cyc  = ready_at + 1;
                mask_port = w;
                exp_maddr = txn_addr;
                exp_mdin  = txn_wdata;
            end
        end
        cyc++;
    endtask

    always @(negedge clk) if (rst_n) model_cycle();

    // ---------------- directed helpers ----------------
    task automatic run_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int rd_n, output int wr_n, output int wr_off, output int rdy_off,
                           output logic [31:0] rdat, output logic er);
        rd_n = 0; wr_n = 0; wr_off = -1; rdy_off = -1; rdat = '0; er = 1'b0;
        @(posedge clk); #1;
        drive(p, 1'b1, w, a, d);
        for (int i = 0; i < 40 && rdy_off < 0; i++) begin
            @(negedge clk);
            if (mem_read_control)  rd_n++;
            if (mem_write_control) begin wr_n++; wr_off = i; end
            if (p_ready(p)) begin rdy_off = i; rdat = p_rdata(p); er = p_err(p); end
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    int tie_order[$];

    task automatic tie_run(input int n);
        tie_order.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h1111_1111);
        drive(1, 1'b1, 1'b0, 32'h3FC, 32'h2222_2222);
        for (int i = 0; i < 200 && tie_order.size() < n; i++) begin
            @(negedge clk);
            if (c_ready) tie_order.push_back(0);
            if (l_ready) tie_order.push_back(1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("tie_count", 32'(tie_order.size()), 32'(n));
    endtask

    // ---------------- random requesters ----------------
    int pending[2];
    int age[2];

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(99);
        if (r < 50)      return 32'($urandom_range(15)) << 2;
        else if (r < 65) return 32'($urandom_range(255)) << 2;
        else if (r < 73) return 32'h0000_03FC;
        else if (r < 83) return (32'($urandom_range(255)) << 2) | 32'($urandom_range(3, 1));
        else if (r < 93) return 32'h0000_0400 + (32'($urandom_range(1023)) << 2);
        else             return 32'hFFFF_FFFC;
    endfunction

    task automatic rand_step(input int p, input bit seen);
        if (pending[p] != 0) begin
            age[p]++;
            if (seen) begin
                pending[p] = 0;
                drive(p, 1'b0, 1'b0, '0, '0);
            end else if (age[p] > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL req_timeout port %0d: got no ready within 100 cycles, required a ready (t=%0t)", p, $time);
                pending[p] = 0;
                drive(p, 1'b0, 1'b0, '0, '0);
            end else if (in_progress(p) && $urandom_range(3) == 0) begin
                // Inputs were latched at grant: scrambling them must not matter.
                drive(p, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom);
            end
        end
        if (pending[p] == 0 && $urandom_range(99) < 40) begin
            pending[p] = 1;
            age[p]     = 0;
            drive(p, 1'b1, 1'($urandom_range(1)), rand_addr(), $urandom);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          rd_n, wr_n, wr_off, rdy_off, first;
        logic [31:0] rdat, old_w2;
        logic        er;
        logic [1:0]  seen;
        int          diffs;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_read", 32'(mem_read_control), 32'h0);
        check("rst_mem_write", 32'(mem_write_control), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_ready", 32'({l_ready, c_ready}), 32'h0);
        @(negedge clk); #1;
        model_reset();
        rst_n = 1'b1;

        // Core load, 4 strobe cycles, ready at N+5.
        run_txn(0, 1'b0, 32'h10, 32'h0, rd_n, wr_n, wr_off, rdy_off, rdat, er);
        check("ld10_read_cycles", 32'(rd_n), 32'd4);
        check("ld10_write_cycles", 32'(wr_n), 32'd0);
        check("ld10_ready_offset", 32'(rdy_off), 32'd5);
        check("ld10_rdata", rdat, 32'hDEAD_BEEF);
        check("ld10_err", 32'(er), 32'h0);

        // Loader store: one write in N+4, ready in N+5.
        run_txn(1, 1'b1, 32'h20, 32'h1234_5678, rd_n, wr_n, wr_off, rdy_off, rdat, er);
        check("st20_write_cycles", 32'(wr_n), 32'd1);
        check("st20_write_offset", 32'(wr_off), 32'd4);
        check("st20_ready_offset", 32'(rdy_off), 32'd5);
        check("st20_rdata", rdat, 32'h0);

        // Core load of the word just stored.
        run_txn(0, 1'b0, 32'h20, 32'h0, rd_n, wr_n, wr_off, rdy_off, rdat, er);
        check("ld20_rdata", rdat, 32'h1234_5678);

        // Misaligned and out-of-range: error at N+1, no strobes.
        run_txn(0, 1'b0, 32'h13, 32'h0, rd_n, wr_n, wr_off, rdy_off, rdat, er);
        check("mis_ready_offset", 32'(rdy_off), 32'd1);
        check("mis_err", 32'(er), 32'h1);
        check("mis_rdata", rdat, 32'h0);
        check("mis_strobes", 32'(rd_n + wr_n), 32'h0);
        run_txn(0, 1'b1, 32'h400, 32'hCAFE_F00D, rd_n, wr_n, wr_off, rdy_off, rdat, er);
        check("oor_ready_offset", 32'(rdy_off), 32'd1);
        check("oor_err", 32'(er), 32'h1);
        check("oor_strobes", 32'(rd_n + wr_n), 32'h0);

        // Both held: alternate. Last grant was C.
`ifdef DMEM_ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        tie_run(6);
        for (int i = 0; i < tie_order.size(); i++)
            check($sformatf("tie_order[%0d]", i), 32'(tie_order[i]), 32'((first + i) % 2));

        // Randomized traffic against the model.
        pending[0] = 0; pending[1] = 0; age[0] = 0; age[1] = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            seen = {l_ready, c_ready};
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) rand_step(p, seen[p]);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Drain to an unmasked IDLE cycle.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (cyc >= free_at && cyc > mask_cyc) break;
        end
        check("drain_idle", 32'(busy), 32'h0);

        // Store to 0x8 aborted by reset in its second ACCESS cycle.
        old_w2 = mem[2];
        drive(0, 1'b1, 1'b1, 32'h8, 32'hA5A5_5A5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_mem_read", 32'(mem_read_control), 32'h0);
        check("abort_mem_write", 32'(mem_write_control), 32'h0);
        check("abort_mem_address", mem_address, 32'h0);
        check("abort_mem_data_in", mem_data_in, 32'h0);
        check("abort_ready", 32'({l_ready, c_ready}), 32'h0);
        check("abort_c_rdata", c_rdata, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_ready_during_reset", 32'({l_ready, c_ready}), 32'h0);
        check("abort_word2", mem[2], old_w2);
        @(negedge clk); #1;
        model_reset();
        rst_n = 1'b1;

        // First tie after reset goes to C.
        tie_run(2);
        if (tie_order.size() > 0) check("post_reset_tie", 32'(tie_order[0]), 32'h0);

        repeat (8) @(posedge clk);
        #1;
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", 32'(diffs), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test by t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
